// File: rtl/reg_bank_write_arbiter_pkg.sv
// Shared types, constants and helpers for the register-bank write arbiter.
// The optional write-lock feature is enabled with REG_ARB_WR_LOCK_EN.
package reg_arb_pkg;

    localparam int DEF_N_REQ     = 4;
    localparam int DEF_N_REGS    = 8;
    localparam int DEF_REG_WIDTH = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    // Index width for n items; never narrower than one bit.
    function automatic int addr_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/reg_bank_write_arbiter_if.sv
// Requester/bank bus for the write arbiter. With REG_ARB_WR_LOCK_EN defined
// the bus also carries the per-register write-protect vector wr_lock.
interface reg_bank_write_arbiter_if
    import reg_arb_pkg::*;
#(
    parameter int N_REQ     = DEF_N_REQ,
    parameter int N_REGS    = DEF_N_REGS,
    parameter int REG_WIDTH = DEF_REG_WIDTH
);
    localparam int ADDR_W = addr_width(N_REGS);

    logic [N_REQ-1:0]           req;
    logic [N_REQ*ADDR_W-1:0]    req_addr;
    logic [N_REQ*REG_WIDTH-1:0] req_data;
    logic [N_REQ-1:0]           gnt;
    logic [N_REGS-1:0]          reg_enable;
    logic [REG_WIDTH-1:0]       reg_data;
    logic                       busy;
    logic                       err;
`ifdef REG_ARB_WR_LOCK_EN
    logic [N_REGS-1:0]          wr_lock;

    modport master (output req, req_addr, req_data, wr_lock,
                    input  gnt, reg_enable, reg_data, busy, err);
    modport slave  (input  req, req_addr, req_data, wr_lock,
                    output gnt, reg_enable, reg_data, busy, err);
`else
    modport master (output req, req_addr, req_data,
                    input  gnt, reg_enable, reg_data, busy, err);
    modport slave  (input  req, req_addr, req_data,
                    output gnt, reg_enable, reg_data, busy, err);
`endif

endinterface

// File: rtl/reg_bank_write_arbiter_rr_arbiter.sv
// Combinational round-robin picker: rotate the request vector so rr_ptr sits
// at bit 0, take the lowest set bit, then rotate the index back.
module rr_arbiter
    import reg_arb_pkg::*;
#(
    parameter  int N     = DEF_N_REQ,
    localparam int IDX_W = addr_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic             any_req,
    output logic [IDX_W-1:0] winner
);

    logic [2*N-1:0]   doubled;
    logic [N-1:0]     rotated;
    logic [IDX_W-1:0] offset;
    logic [IDX_W:0]   sum;

    assign doubled = {req, req};
    assign rotated = doubled[rr_ptr +: N];
    assign any_req = |req;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        offset = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rotated[i]) offset = IDX_W'(i);
        end
    end

    // N need not be a power of two, so wrap explicitly instead of truncating.
    assign sum    = {1'b0, offset} + {1'b0, rr_ptr};
    assign winner = (sum >= (IDX_W + 1)'(N)) ? IDX_W'(sum - (IDX_W + 1)'(N))
                                             : sum[IDX_W-1:0];

endmodule

// File: rtl/reg_bank_write_arbiter.sv
// Round-robin write arbiter: the single writer of a shared register bank.
// Define REG_ARB_WR_LOCK_EN to honour the per-register wr_lock protection.
module reg_bank_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter int N_REQ     = DEF_N_REQ,
    parameter int N_REGS    = DEF_N_REGS,
    parameter int REG_WIDTH = DEF_REG_WIDTH
) (
    input logic                     clk,
    input logic                     s_reset,
    reg_bank_write_arbiter_if.slave bus
);

    localparam int ADDR_W = addr_width(N_REGS);
    localparam int IDX_W  = addr_width(N_REQ);

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     rr_ptr_q, winner_q, winner, next_ptr;
    logic [ADDR_W-1:0]    addr_q, sel_addr;
    logic [REG_WIDTH-1:0] data_q, sel_data;
    logic                 any_req, addr_ok, locked, busy, err;
    logic [N_REQ-1:0]     gnt;
    logic [N_REGS-1:0]    reg_en;

    rr_arbiter #(.N(N_REQ)) u_rr_arbiter (
        .req     (bus.req),
        .rr_ptr  (rr_ptr_q),
        .any_req (any_req),
        .winner  (winner)
    );

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (winner == IDX_W'(i)) begin
                sel_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
                sel_data = bus.req_data[i*REG_WIDTH +: REG_WIDTH];
            end
        end
    end

    assign next_ptr = (winner_q == IDX_W'(N_REQ - 1)) ? '0 : winner_q + IDX_W'(1);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (s_reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            winner_q <= '0;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && any_req) begin
                winner_q <= winner;
                addr_q   <= sel_addr;
                data_q   <= sel_data;
            end
            if (state_q == WRITE) rr_ptr_q <= next_ptr;
        end
    end

    assign addr_ok = int'(addr_q) < N_REGS;

`ifdef REG_ARB_WR_LOCK_EN
    always_comb begin
        locked = 1'b0;
        for (int j = 0; j < N_REGS; j++) begin
            if (addr_q == ADDR_W'(j)) locked = bus.wr_lock[j];
        end
    end
`else
    assign locked = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        gnt     = '0;
        reg_en  = '0;
        busy    = 1'b0;
        err     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_req) state_d = WRITE;
            end
            WRITE: begin
                state_d = IDLE;
                busy    = 1'b1;
                for (int i = 0; i < N_REQ; i++) gnt[i] = (winner_q == IDX_W'(i));
                if (addr_ok && !locked) begin
                    for (int j = 0; j < N_REGS; j++) reg_en[j] = (addr_q == ADDR_W'(j));
                end else begin
                    err = 1'b1;
                end
            end
        endcase
    end

    // A write must never reach the bank while reset is asserted, even mid-WRITE.
    assign bus.reg_enable = s_reset ? '0 : reg_en;
    assign bus.gnt        = gnt;
    assign bus.reg_data   = data_q;
    assign bus.busy       = busy;
    assign bus.err        = err;

endmodule

// File: tb/tb_reg_bank_write_arbiter.sv
// Self-checking bench for reg_bank_write_arbiter (N_REGS=6 to exercise bad
// addresses); lock vectors run only when REG_ARB_WR_LOCK_EN is defined.
module tb_reg_bank_write_arbiter;
    import reg_arb_pkg::*;

    localparam int N_REQ     = 4;
    localparam int N_REGS    = 6;
    localparam int REG_WIDTH = 8;
    localparam int ADDR_W    = addr_width(N_REGS);

    typedef logic [N_REQ*ADDR_W-1:0]    addr_vec_t;
    typedef logic [N_REQ*REG_WIDTH-1:0] data_vec_t;

    typedef struct {
        logic                 rst;
        logic [N_REQ-1:0]     req;
        addr_vec_t            addr;
        data_vec_t            data;
        logic [N_REQ-1:0]     gnt;
        logic [N_REGS-1:0]    en;
        logic                 busy;
        logic                 err;
        logic [REG_WIDTH-1:0] rd;
    } vec_t;

    logic clk = 1'b0;
    logic s_reset;
    always #5 clk = ~clk;

    reg_bank_write_arbiter_if #(.N_REQ(N_REQ), .N_REGS(N_REGS), .REG_WIDTH(REG_WIDTH)) bus ();

    reg_bank_write_arbiter #(.N_REQ(N_REQ), .N_REGS(N_REGS), .REG_WIDTH(REG_WIDTH)) dut (
        .clk     (clk),
        .s_reset (s_reset),
        .bus     (bus.slave)
    );

    // Register bank driven only by the arbiter outputs.
    logic [REG_WIDTH-1:0] bank [N_REGS] = '{default: '0};
    always @(posedge clk) begin
        for (int i = 0; i < N_REGS; i++)
            if (bus.reg_enable[i] === 1'b1) bank[i] <= bus.reg_data;
    end

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model: phase flag plus the latched winner, address and data.
    bit                   m_write;
    int                   m_win, m_addr, m_ptr;
    logic [REG_WIDTH-1:0] m_data;
    logic [REG_WIDTH-1:0] bank_exp [N_REGS] = '{default: '0};

    logic [N_REQ-1:0]     act_gnt;
    logic [N_REGS-1:0]    act_en;
    logic                 act_busy, act_err;
    logic [REG_WIDTH-1:0] act_rd;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, advance at the edge.
    task automatic step(input logic rst, input logic [N_REQ-1:0] r, input addr_vec_t a,
                        input data_vec_t d, input logic [N_REGS-1:0] lk);
        logic [N_REQ-1:0]  e_gnt;
        logic [N_REGS-1:0] e_en, lk_eff;
        logic              e_err;
        int                k, idx;
        bit                found;
        s_reset      = rst;
        bus.req      = r;
        bus.req_addr = a;
        bus.req_data = d;
`ifdef REG_ARB_WR_LOCK_EN
        bus.wr_lock  = lk;
        lk_eff       = lk;
`else
        lk_eff       = '0;
`endif
        #2;
        e_gnt = '0;
        e_en  = '0;
        e_err = 1'b0;
        if (m_write) begin
            e_gnt[m_win] = 1'b1;
            if (m_addr >= N_REGS) e_err = 1'b1;
            else if (lk_eff[m_addr]) e_err = 1'b1;
            else if (!rst) e_en[m_addr] = 1'b1;
        end
        act_gnt  = bus.gnt;
        act_en   = bus.reg_enable;
        act_busy = bus.busy;
        act_err  = bus.err;
        act_rd   = bus.reg_data;
        check("gnt", 32'(act_gnt), 32'(e_gnt));
        check("reg_enable", 32'(act_en), 32'(e_en));
        check("busy", 32'(act_busy), 32'(m_write));
        check("err", 32'(act_err), 32'(e_err));
        check("reg_data", 32'(act_rd), 32'(m_data));
        @(posedge clk);
        if (e_en != '0) bank_exp[m_addr] = m_data;
        if (rst) begin
            m_write = 1'b0;
            m_ptr   = 0;
            m_data  = '0;
        end else if (m_write) begin
            m_write = 1'b0;
            m_ptr   = (m_win + 1) % N_REQ;
        end else begin
            found = 1'b0;
            for (k = 0; k < N_REQ; k++) begin
                idx = (m_ptr + k) % N_REQ;
                if (!found && r[idx]) begin
                    found   = 1'b1;
                    m_win   = idx;
                    m_addr  = int'(a[idx*ADDR_W +: ADDR_W]);
                    m_data  = d[idx*REG_WIDTH +: REG_WIDTH];
                    m_write = 1'b1;
                end
            end
        end
        #1;
    endtask

    task automatic add(input logic rst, input logic [N_REQ-1:0] r, input addr_vec_t a,
                       input data_vec_t d, input logic [N_REQ-1:0] g, input logic [N_REGS-1:0] en,
                       input logic b, input logic e, input logic [REG_WIDTH-1:0] rd);
        vec_t v;
        v.rst = rst; v.req = r; v.addr = a; v.data = d;
        v.gnt = g; v.en = en; v.busy = b; v.err = e; v.rd = rd;
        tbl.push_back(v);
    endtask

    initial begin
        addr_vec_t a_rand;
        data_vec_t d_rand;
        localparam addr_vec_t A1 = 12'h003;          // req0 -> reg3
        localparam data_vec_t D1 = 32'h0000_00A5;
        localparam addr_vec_t A2 = 12'h688;          // req i -> reg i
        localparam data_vec_t D2 = 32'h1312_1110;
        localparam addr_vec_t A3 = 12'h038;          // req1 -> addr 7 (out of range)
        localparam data_vec_t D3 = 32'h0000_EE00;
        localparam addr_vec_t A4 = 12'h040;          // req2 -> reg1
        localparam data_vec_t D4 = 32'h003C_0000;

        // Single write, then a reset, then continuous all-request rotation, then a bad address.
        add(1, 4'b0000, '0, '0, 4'b0000, 6'h00, 0, 0, 8'h00);
        add(0, 4'b0001, A1, D1, 4'b0000, 6'h00, 0, 0, 8'h00);
        add(0, 4'b0001, A1, D1, 4'b0001, 6'h08, 1, 0, 8'hA5);
        add(0, 4'b0000, A1, D1, 4'b0000, 6'h00, 0, 0, 8'hA5);
        add(1, 4'b0000, '0, '0, 4'b0000, 6'h00, 0, 0, 8'hA5);
        add(0, 4'b1111, A2, D2, 4'b0000, 6'h00, 0, 0, 8'h00);
        add(0, 4'b1111, A2, D2, 4'b0001, 6'h01, 1, 0, 8'h10);
        add(0, 4'b1111, A2, D2, 4'b0000, 6'h00, 0, 0, 8'h10);
        add(0, 4'b1111, A2, D2, 4'b0010, 6'h02, 1, 0, 8'h11);
        add(0, 4'b1111, A2, D2, 4'b0000, 6'h00, 0, 0, 8'h11);
        add(0, 4'b1111, A2, D2, 4'b0100, 6'h04, 1, 0, 8'h12);
        add(0, 4'b1111, A2, D2, 4'b0000, 6'h00, 0, 0, 8'h12);
        add(0, 4'b1111, A2, D2, 4'b1000, 6'h08, 1, 0, 8'h13);
        add(0, 4'b1111, A2, D2, 4'b0000, 6'h00, 0, 0, 8'h13);
        add(0, 4'b1111, A2, D2, 4'b0001, 6'h01, 1, 0, 8'h10);
        add(0, 4'b0000, A2, D2, 4'b0000, 6'h00, 0, 0, 8'h10);
        add(0, 4'b0010, A3, D3, 4'b0000, 6'h00, 0, 0, 8'h10);
        add(0, 4'b0010, A3, D3, 4'b0010, 6'h00, 1, 1, 8'hEE);
        add(0, 4'b0000, A3, D3, 4'b0000, 6'h00, 0, 0, 8'hEE);

        s_reset      = 1'b1;
        bus.req      = '0;
        bus.req_addr = '0;
        bus.req_data = '0;
`ifdef REG_ARB_WR_LOCK_EN
        bus.wr_lock  = '0;
`endif
        repeat (2) @(posedge clk);
        #1;
        m_write = 1'b0; m_ptr = 0; m_win = 0; m_addr = 0; m_data = '0;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].req, tbl[i].addr, tbl[i].data, '0);
            check($sformatf("tbl%0d_gnt", i), 32'(act_gnt), 32'(tbl[i].gnt));
            check($sformatf("tbl%0d_en", i), 32'(act_en), 32'(tbl[i].en));
            check($sformatf("tbl%0d_busy", i), 32'(act_busy), 32'(tbl[i].busy));
            check($sformatf("tbl%0d_err", i), 32'(act_err), 32'(tbl[i].err));
            check($sformatf("tbl%0d_rd", i), 32'(act_rd), 32'(tbl[i].rd));
            if (i == 3) check("bank3_after_first_write", 32'(bank[3]), 32'h0000_00A5);
        end
        for (int j = 0; j < N_REGS; j++)
            check($sformatf("bank%0d_after_table", j), 32'(bank[j]),
                  (j < 4) ? 32'h10 + 32'(j) : 32'h0);

        // Reset during the WRITE cycle of req2 -> reg1: write dropped, pointer back to 0.
        step(0, 4'b0100, A4, D4, '0);
        step(1, 4'b0100, A4, D4, '0);
        check("rst_in_write_gnt", 32'(act_gnt), 32'h4);
        check("rst_in_write_en", 32'(act_en), 32'h0);
        step(0, 4'b1111, A2, D2, '0);
        check("post_rst_idle_busy", 32'(act_busy), 32'h0);
        step(0, 4'b1111, A2, D2, '0);
        check("post_rst_gnt_req0", 32'(act_gnt), 32'h1);
        check("reg1_untouched", 32'(bank[1]), 32'h11);
        step(0, 4'b0000, A2, D2, '0);

        // req0 pulsed and withdrawn inside one IDLE cycle: never sampled, never serviced.
        bus.req = 4'b0001;
        #3;
        bus.req = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            step(0, 4'b0000, A1, D1, '0);
            check("dropped_req_busy", 32'(act_busy), 32'h0);
            check("dropped_req_gnt", 32'(act_gnt), 32'h0);
        end

`ifdef REG_ARB_WR_LOCK_EN
        // Locked reg2 rejects the write with err; unlocked reg3 writes normally.
        step(0, 4'b0001, 12'h002, 32'h5A, 6'h04);
        step(0, 4'b0001, 12'h002, 32'h5A, 6'h04);
        check("lock_gnt", 32'(act_gnt), 32'h1);
        check("lock_en", 32'(act_en), 32'h0);
        check("lock_err", 32'(act_err), 32'h1);
        step(0, 4'b0000, 12'h003, 32'h77, 6'h04);
        step(0, 4'b0001, 12'h003, 32'h77, 6'h04);
        step(0, 4'b0001, 12'h003, 32'h77, 6'h04);
        check("unlocked_en", 32'(act_en), 32'h08);
        check("unlocked_err", 32'(act_err), 32'h0);
        step(0, 4'b0000, 12'h003, 32'h77, 6'h04);
        check("reg3_unlocked_write", 32'(bank[3]), 32'h77);
        check("reg2_locked_kept", 32'(bank[2]), 32'h12);
`endif

        // Random traffic against the model, including occasional resets and bad addresses.
        for (int c = 0; c < 600; c++) begin
            a_rand = addr_vec_t'($urandom);
            d_rand = data_vec_t'($urandom);
            step(($urandom_range(0, 49) == 0), N_REQ'($urandom), a_rand, d_rand,
                 N_REGS'($urandom));
        end
        step(0, 4'b0000, '0, '0, '0);
        for (int j = 0; j < N_REGS; j++)
            check($sformatf("bank%0d_final", j), 32'(bank[j]), 32'(bank_exp[j]));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_bank_write_arbiter.md
Name: reg_bank_write_arbiter

Overview:
Shares one bank of N_REGS generic_register instances between N_REQ write requesters. Uses round-robin arbitration with a req/gnt handshake. Drives a one-hot register enable vector and a shared data bus into the bank. Sits between the control-side masters and the register bank; it is the only writer of the bank.

Parameters:
N_REQ, 4, number of requesters (2..8)
N_REGS, 8, number of registers in the bank (2..16; need not be a power of 2)
REG_WIDTH, 8, register data width
ADDR_W, $clog2(N_REGS), localparam, width of each request address

Ports:
clk  in  1  system clock, all logic on rising edge
s_reset  in  1  synchronous, active-high reset
req  in  N_REQ  per-requester write request, level, held until granted
req_addr  in  N_REQ*ADDR_W  packed target addresses, requester i at [i*ADDR_W +: ADDR_W]
req_data  in  N_REQ*REG_WIDTH  packed write data, requester i at [i*REG_WIDTH +: REG_WIDTH]
gnt  out  N_REQ  one-hot grant, 1-cycle pulse
reg_enable  out  N_REGS  one-hot write enable to the bank, 1-cycle pulse
reg_data  out  REG_WIDTH  shared data to every register's data input
busy  out  1  high while in WRITE state
err  out  1  1-cycle pulse; granted access was rejected (bad address or lock)

Behaviour:
- Reset: the single clock and reset are one clock; reset is synchronous and active-high. At the first clk edge with s_reset=1:
  - state=IDLE, rr_ptr=0.
  - gnt, reg_enable, reg_data, busy and err all go to 0.
- reg_enable is additionally gated combinationally by !s_reset, so no bank write occurs during any cycle with s_reset high.
- FSM states: IDLE and WRITE.
- IDLE:
  - If any req is high, select the winner by round-robin starting at index rr_ptr, searching upward with wrap at N_REQ.
  - Latch the winner index, its addr and its data. Next state is WRITE.
  - If no req is high, stay in IDLE.
- WRITE (exactly 1 cycle):
  - gnt[winner]=1, busy=1, reg_data=latched data.
  - reg_enable[latched addr]=1 if addr < N_REGS.
  - rr_ptr = (winner+1) mod N_REQ. Next state is always IDLE.
- Latency: req sampled high in IDLE at edge T; gnt and reg_enable are high in cycle T+1; the register holds the data after edge T+2.
- Throughput: at most one write per 2 cycles.
- Handshake:
  - Requester holds req, addr and data stable until it samples gnt=1.
  - It deasserts req, or presents a new request, on that same edge.
  - Since the IDLE cycle follows WRITE, a still-high req is treated as a new request.
  - Dropping req before gnt is permitted; that request is simply not serviced.
- Bad address (addr >= N_REGS): gnt is still issued, reg_enable stays all-zero, err=1 in the WRITE cycle.
- Fairness: with all N_REQ requesting continuously, each is granted exactly once per N_REQ grants.
- reg_data keeps its last value when not in WRITE; reg_enable=0 makes it don't-care.
- s_reset during WRITE: the write is suppressed, gnt is cleared at the edge, and the FSM returns to IDLE with rr_ptr=0.

Optional Feature:
Macro: REG_ARB_WR_LOCK_EN
- Defined:
  - Adds input wr_lock [N_REGS]; a set bit write-protects that register.
  - A granted access to a locked address gets gnt=1, reg_enable all-zero, err=1.
  - wr_lock is sampled in the WRITE cycle.
- Undefined: the port is absent and every in-range address is writable.

Decomposition:
- Package reg_arb_pkg holds:
  - state typedef (IDLE, WRITE);
  - the addr-width function (clog2 with a minimum of 1);
  - the default parameter constants.
- Sub-module rr_arbiter (parameter N):
  - inputs: req vector, rr_ptr;
  - outputs: any_req, winner index;
  - purely combinational rotate/priority-encode/unrotate.
- The top level holds the FSM, pointer and output registers.

Test Plan:
1. Reset, then req=4'b0001, addr0=3, data0=8'hA5 -> gnt=0001 and reg_enable=8'h08 two cycles after request; bank reg3=8'hA5; err=0.
2. req=4'b1111 held high, re-asserted after each grant -> grants in order 0,1,2,3,0 on cycles T+1, T+3, T+5, T+7, T+9; each requester's data lands in its addressed register.
3. N_REGS=6, req1 with addr=7 -> gnt=0010, reg_enable=0, err=1 for 1 cycle; bank unchanged.
4. s_reset pulsed in the WRITE cycle of a req2 write of 8'h3C to addr 1 -> reg1 unchanged, gnt cleared, next grant with req=1111 goes to requester 0.
5. req0 dropped in IDLE before sampling -> no gnt and no write; busy stays 0.
6. With REG_ARB_WR_LOCK_EN, wr_lock=8'h04, write addr 2 -> gnt=1, reg_enable=0, err=1; write addr 3 -> normal write, err=0.
